// File: rtl/wb_ppfifo_to_mem.sv
// wb_ppfifo_to_mem
//   Wishbone write master that drains 32-bit words from a ping-pong FIFO read
//   port into two host-armed memory regions (slot 0 / slot 1), alternating
//   between them as each fills or is flushed.
//
// Ports
//   clk, rst                       : clock, asynchronous active-low reset
//   debug                          : {cyc, act, flush pending, active slot, state}
//   i_enable, i_flush              : start-permit level, early-close strobe
//   i_memory_N_base/size/ready     : slot configuration and arm strobe
//   o_memory_N_count/finished/empty: slot progress and status
//   o_default_mem_N_base           : parameter constants for the register file
//   o_write_finished               : one-cycle pulse when any slot completes
//   o_mem_*, i_mem_*               : Wishbone master (write only)
//   i_ppfifo_*, o_ppfifo_*         : ping-pong FIFO read side
module wb_ppfifo_to_mem #(
  parameter logic [31:0] DEFAULT_MEM_0_BASE = 32'h0000_0000,
  parameter logic [31:0] DEFAULT_MEM_1_BASE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  output logic [31:0] o_memory_0_count,
  input  logic        i_memory_0_ready,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  output logic [31:0] o_memory_1_count,
  input  logic        i_memory_1_ready,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic [31:0] o_default_mem_0_base,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_write_finished,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic        i_ppfifo_rdy,
  output logic        o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  input  logic [31:0] i_ppfifo_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state;
  logic        active;
  logic        flush_pending;
  logic [23:0] block_cnt;

  logic [31:0] base     [2];
  logic [31:0] size     [2];
  logic [31:0] count    [2];
  logic [1:0]  finished;
  logic [1:0]  empty;

  logic [1:0]  ready;
  logic [31:0] base_in  [2];
  logic [31:0] size_in  [2];
  logic        slot_ok;
  logic [31:0] count_inc;
  logic        unused_inputs;

  assign ready      = {i_memory_1_ready, i_memory_0_ready};
  assign base_in[0] = i_memory_0_base;
  assign base_in[1] = i_memory_1_base;
  assign size_in[0] = i_memory_0_size;
  assign size_in[1] = i_memory_1_size;

  // A slot can take words only while armed and not yet complete.
  assign slot_ok   = !empty[active] && !finished[active];
  assign count_inc = count[active] + 32'd1;

  assign o_memory_0_count     = count[0];
  assign o_memory_1_count     = count[1];
  assign o_memory_0_finished  = finished[0];
  assign o_memory_1_finished  = finished[1];
  assign o_memory_0_empty     = empty[0];
  assign o_memory_1_empty     = empty[1];
  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;
  assign o_mem_sel            = 4'hF;
  assign debug = {24'd0, o_mem_cyc, o_ppfifo_act, flush_pending, active, 2'b00, state};

  // Read data and interrupt from the slave are not needed by a write-only master.
  assign unused_inputs = ^{i_mem_dat, i_mem_int};

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      active           <= 1'b0;
      flush_pending    <= 1'b0;
      block_cnt        <= '0;
      o_ppfifo_act     <= 1'b0;
      o_ppfifo_stb     <= 1'b0;
      o_mem_cyc        <= 1'b0;
      o_mem_stb        <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_adr        <= '0;
      o_mem_dat        <= '0;
      o_write_finished <= 1'b0;
      finished         <= '0;
      empty            <= '1;
      // NOTE: the two-entry slot tables are plain flops, not RAM, so they are
      // reset like any other register; empty/count must be defined from reset.
      for (int i = 0; i < 2; i++) begin
        base[i]  <= '0;
        size[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      o_ppfifo_stb     <= 1'b0;
      o_write_finished <= 1'b0;

      // Arming never collides with the FSM's updates: the FSM only touches the
      // active slot while it is armed and unfinished, when strobes are ignored.
      for (int i = 0; i < 2; i++) begin
        if (ready[i] && (empty[i] || finished[i]) && size_in[i] != 32'd0) begin
          base[i]     <= base_in[i];
          size[i]     <= size_in[i];
          count[i]    <= '0;
          empty[i]    <= 1'b0;
          finished[i] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (flush_pending) begin
            if (!empty[active] && count[active] != 32'd0) begin
              finished[active] <= 1'b1;
              empty[active]    <= 1'b1;
              o_write_finished <= 1'b1;
              active           <= ~active;
            end
            flush_pending <= 1'b0;
          end else if (i_enable && i_ppfifo_rdy && slot_ok) begin
            o_ppfifo_act <= 1'b1;
            block_cnt    <= i_ppfifo_size;
            state        <= READ;
          end
        end

        READ: begin
          if (block_cnt == 24'd0) begin
            o_ppfifo_act <= 1'b0;
            state        <= IDLE;
          end else if (slot_ok) begin
            // Data is captured now; the pop strobe is seen by the FIFO during
            // the following cycle, so the next word is ready by the next READ.
            o_ppfifo_stb <= 1'b1;
            o_mem_dat    <= i_ppfifo_data;
            o_mem_adr    <= base[active] + count[active];
            block_cnt    <= block_cnt - 24'd1;
            o_mem_cyc    <= 1'b1;
            o_mem_stb    <= 1'b1;
            o_mem_we     <= 1'b1;
            state        <= WRITE;
          end
          // Otherwise hold act and wait for the active slot to be armed.
        end

        WRITE: begin
          if (i_mem_ack) begin
            o_mem_cyc     <= 1'b0;
            o_mem_stb     <= 1'b0;
            o_mem_we      <= 1'b0;
            count[active] <= count_inc;
            if (count_inc == size[active]) begin
              finished[active] <= 1'b1;
              empty[active]    <= 1'b1;
              o_write_finished <= 1'b1;
              active           <= ~active;
            end
            state <= READ;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed last so a request arriving on the servicing cycle is kept.
      if (i_flush) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_ppfifo_to_mem.sv
// Self-checking bench for wb_ppfifo_to_mem: a FIFO source model, a Wishbone
// slave with programmable ack delay, and a scoreboard of expected writes.
module tb_wb_ppfifo_to_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug;
  logic        i_enable, i_flush;
  logic [31:0] i_memory_0_base, i_memory_0_size, o_memory_0_count;
  logic [31:0] i_memory_1_base, i_memory_1_size, o_memory_1_count;
  logic        i_memory_0_ready, i_memory_1_ready;
  logic        o_memory_0_finished, o_memory_1_finished;
  logic        o_memory_0_empty, o_memory_1_empty;
  logic [31:0] o_default_mem_0_base, o_default_mem_1_base;
  logic        o_write_finished;
  logic        o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [31:0] i_mem_dat = '0;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_int = 1'b0;
  logic        i_ppfifo_rdy;
  logic        o_ppfifo_act;
  logic [23:0] i_ppfifo_size;
  logic        o_ppfifo_stb;
  logic [31:0] i_ppfifo_data;

  wb_ppfifo_to_mem dut (
    .clk(clk), .rst(rst), .debug(debug),
    .i_enable(i_enable), .i_flush(i_flush),
    .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
    .o_memory_0_count(o_memory_0_count), .i_memory_0_ready(i_memory_0_ready),
    .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
    .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
    .o_memory_1_count(o_memory_1_count), .i_memory_1_ready(i_memory_1_ready),
    .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
    .o_default_mem_0_base(o_default_mem_0_base), .o_default_mem_1_base(o_default_mem_1_base),
    .o_write_finished(o_write_finished),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
    .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
    .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
    .i_ppfifo_data(i_ppfifo_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t  exp_q[$];
  int   blk[$];
  int   rd_idx;
  int   ack_delay;
  int   wait_cnt;
  int   cyc_len;
  int   cyc_lens[$];
  int   stb_pulses;
  int   wf_pulses;
  bit   act_seen;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // FIFO source, Wishbone slave and scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    if (o_ppfifo_stb) begin
      stb_pulses++;
      rd_idx++;
      i_ppfifo_data = blk[rd_idx];
    end
    if (o_write_finished) wf_pulses++;
    if (o_ppfifo_act) act_seen = 1'b1;
    if (o_mem_cyc && o_mem_stb && !i_mem_ack) begin
      cyc_len++;
      if (wait_cnt == ack_delay) begin
        i_mem_ack = 1'b1;
        cyc_lens.push_back(cyc_len);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", o_mem_adr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("sb_adr", o_mem_adr, e.adr);
          check("sb_dat", o_mem_dat, e.dat);
          check("sb_we_sel", {27'd0, o_mem_we, o_mem_sel}, {27'd0, 1'b1, 4'hF});
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      wait_cnt  = 0;
      cyc_len   = 0;
    end
  end

  task automatic push_exp(input logic [31:0] adr, input logic [31:0] dat);
    wr_t e;
    e.adr = adr;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_enable = 1'b1;
    i_flush = 1'b0;
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
    i_ppfifo_rdy = 1'b0;
    i_ppfifo_size = '0;
    ack_delay = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stb_pulses = 0;
    wf_pulses = 0;
    act_seen = 1'b0;
    cyc_lens.delete();
  endtask

  task automatic arm(input int slot, input logic [31:0] base, input logic [31:0] size);
    if (slot == 0) begin
      i_memory_0_base = base; i_memory_0_size = size; i_memory_0_ready = 1'b1;
    end else begin
      i_memory_1_base = base; i_memory_1_size = size; i_memory_1_ready = 1'b1;
    end
    @(negedge clk);
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
  endtask

  task automatic load_block(input int n, input int first);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(first + i);
    rd_idx = 0;
    i_ppfifo_data = blk[0];
    i_ppfifo_size = n[23:0];
    i_ppfifo_rdy = 1'b1;
  endtask

  task automatic wait_act(input logic level, input int max_cycles, input string tag);
    int n = 0;
    while (o_ppfifo_act !== level && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, o_ppfifo_act}, {31'd0, level});
  endtask

  task automatic run_block(input string tag);
    wait_act(1'b1, 50, {tag, "_act_rise"});
    i_ppfifo_rdy = 1'b0;
    wait_act(1'b0, 500, {tag, "_act_fall"});
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    i_memory_0_base = '0; i_memory_0_size = '0;
    i_memory_1_base = '0; i_memory_1_size = '0;
    i_ppfifo_data = '0;
    rd_idx = 0; wait_cnt = 0; cyc_len = 0;
    #1;
    check("rst_async_outputs", {o_mem_cyc, o_mem_stb, o_mem_we, o_ppfifo_act, o_ppfifo_stb}, 0);
    do_reset();

    // Reset state
    check("rst_counts", o_memory_0_count | o_memory_1_count, 0);
    check("rst_flags", {o_memory_1_empty, o_memory_0_empty, o_memory_1_finished, o_memory_0_finished}, 4'b1100);
    check("rst_debug", debug, 0);
    check("rst_bus", {o_mem_cyc, o_mem_stb, o_mem_we, o_ppfifo_act, o_ppfifo_stb, o_write_finished}, 0);
    check("default_base0", o_default_mem_0_base, 32'h0000_0000);
    check("default_base1", o_default_mem_1_base, 32'h0010_0000);

    // 1: single 4-word block fills slot 0 exactly
    arm(0, 32'h100, 32'd4);
    for (int i = 0; i < 4; i++) push_exp(32'h100 + i, 1 + i);
    load_block(4, 1);
    run_block("t1");
    check("t1_count0", o_memory_0_count, 4);
    check("t1_fin_empty0", {o_memory_0_finished, o_memory_0_empty}, 2'b11);
    check("t1_wf_pulses", wf_pulses, 1);
    check("t1_active", debug[4], 1'b1);
    check("t1_stb_pulses", stb_pulses, 4);
    check("t1_sb_drain", exp_q.size(), 0);

    // 2: 5-word block spills from slot 0 into slot 1
    do_reset();
    arm(0, 32'h200, 32'd3);
    arm(1, 32'h300, 32'd3);
    for (int i = 0; i < 3; i++) push_exp(32'h200 + i, 1 + i);
    push_exp(32'h300, 4);
    push_exp(32'h301, 5);
    load_block(5, 1);
    run_block("t2");
    check("t2_count0", o_memory_0_count, 3);
    check("t2_fin0", o_memory_0_finished, 1'b1);
    check("t2_count1", o_memory_1_count, 2);
    check("t2_fin_empty1", {o_memory_1_finished, o_memory_1_empty}, 2'b00);
    check("t2_act_low", o_ppfifo_act, 1'b0);
    check("t2_wf_pulses", wf_pulses, 1);
    check("t2_sb_drain", exp_q.size(), 0);

    // 3: partial fill then flush; second flush on an empty slot does nothing
    do_reset();
    arm(0, 32'h400, 32'd8);
    for (int i = 0; i < 3; i++) push_exp(32'h400 + i, 32'h50 + i);
    load_block(3, 32'h50);
    run_block("t3");
    check("t3_fin0_before", o_memory_0_finished, 1'b0);
    pulse_flush();
    check("t3_fin0_after", {o_memory_0_finished, o_memory_0_empty}, 2'b11);
    check("t3_count0", o_memory_0_count, 3);
    check("t3_wf_pulses", wf_pulses, 1);
    check("t3_active", debug[4], 1'b1);
    pulse_flush();
    check("t3_flush2_fin1", o_memory_1_finished, 1'b0);
    check("t3_flush2_wf", wf_pulses, 1);
    check("t3_flush2_state", debug[5:0], 6'b010000);
    check("t3_sb_drain", exp_q.size(), 0);

    // 4: ack delayed 5 cycles holds cyc/stb for 6 cycles per word
    do_reset();
    ack_delay = 5;
    arm(0, 32'h40, 32'd2);
    push_exp(32'h40, 32'hA);
    push_exp(32'h41, 32'hB);
    load_block(2, 32'hA);
    run_block("t4");
    check("t4_txns", cyc_lens.size(), 2);
    for (int i = 0; i < cyc_lens.size(); i++) check("t4_cyc_len", cyc_lens[i], 6);
    check("t4_stb_pulses", stb_pulses, 2);
    check("t4_sb_drain", exp_q.size(), 0);

    // 5: enable low blocks a ready FIFO; raising it starts within 2 cycles
    do_reset();
    i_enable = 1'b0;
    arm(0, 32'h500, 32'd4);
    push_exp(32'h500, 32'h77);
    push_exp(32'h501, 32'h78);
    load_block(2, 32'h77);
    act_seen = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_act", act_seen, 1'b0);
    i_enable = 1'b1;
    n = 0;
    while (!o_ppfifo_act && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_start_latency_ok", (n >= 1 && n <= 2), 1'b1);
    i_ppfifo_rdy = 1'b0;
    wait_act(1'b0, 500, "t5_act_fall");
    check("t5_count0", o_memory_0_count, 2);
    check("t5_sb_drain", exp_q.size(), 0);

    // 6: asynchronous reset in the middle of a write
    do_reset();
    arm(0, 32'h700, 32'd8);
    push_exp(32'h700, 32'h11);
    push_exp(32'h701, 32'h12);
    load_block(2, 32'h11);
    run_block("t6a");
    check("t6_count0_pre", o_memory_0_count, 2);
    ack_delay = 20;
    load_block(2, 32'h21);
    n = 0;
    while (!o_mem_cyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_write", {o_mem_cyc, o_ppfifo_act}, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_drop", {o_mem_cyc, o_mem_stb, o_mem_we, o_ppfifo_act, o_ppfifo_stb}, 0);
    i_ppfifo_rdy = 1'b0;
    ack_delay = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_counts", o_memory_0_count | o_memory_1_count, 0);
    check("t6_empty", {o_memory_1_empty, o_memory_0_empty}, 2'b11);
    check("t6_debug", debug, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_ppfifo_to_mem.md
Name: wb_ppfifo_to_mem

Overview:
Wishbone bus master that drains 32-bit words from the read side of a ping-pong FIFO and writes them into one of two host-configured memory regions (slots 0 and 1), alternating between them. It sits between a streaming capture source (e.g. a camera) and the memory arbiter. Per-slot progress, completion and empty flags are reported to a register-file wrapper, which raises interrupts from them.

Parameters:
DEFAULT_MEM_0_BASE, 32'h00000000, value driven on o_default_mem_0_base.
DEFAULT_MEM_1_BASE, 32'h00100000, value driven on o_default_mem_1_base.

Ports:
clk  in  1  system clock; all logic is synchronous to its rising edge.
rst  in  1  reset, asynchronous and active-low.
debug  out  32  [3:0] state, [4] active slot, [5] flush pending, [6] o_ppfifo_act, [7] o_mem_cyc, rest 0.
i_enable  in  1  permits starting new FIFO blocks.
i_flush  in  1  one-cycle request to close out the active slot early.
i_memory_0_base / i_memory_1_base  in  32  slot base word address.
i_memory_0_size / i_memory_1_size  in  32  slot capacity in words.
o_memory_0_count / o_memory_1_count  out  32  words written into the slot since it was armed.
i_memory_0_ready / i_memory_1_ready  in  1  one-cycle arm strobe.
o_memory_0_finished / o_memory_1_finished  out  1  slot complete.
o_memory_0_empty / o_memory_1_empty  out  1  slot not armed.
o_default_mem_0_base / o_default_mem_1_base  out  32  parameter constants.
o_write_finished  out  1  one-cycle pulse when any slot finishes.
o_mem_we, o_mem_stb, o_mem_cyc  out  1  Wishbone master controls.
o_mem_sel  out  4  always 4'hF.
o_mem_adr  out  32  word address.
o_mem_dat  out  32  write data.
i_mem_dat  in  32  unused.
i_mem_ack  in  1  slave acknowledge.
i_mem_int  in  1  unused.
i_ppfifo_rdy  in  1  a FIFO block is available.
o_ppfifo_act  out  1  block claimed.
i_ppfifo_size  in  24  word count of the claimed block.
o_ppfifo_stb  out  1  pop one word.
i_ppfifo_data  in  32  current word, valid while act is high.

Behaviour:
- Reset state:
  - All bus and FIFO outputs are 0.
  - Both counts are 0, both finished flags are 0, both empty flags are 1.
  - Active slot is 0; state is IDLE; flush pending is 0.
- Arming a slot:
  - A ready strobe on a slot that is empty or finished latches base and size, clears count, sets empty=0 and clears finished.
  - A ready strobe on a slot that is armed and unfinished is ignored.
  - A slot is armed only when size > 0; a strobe with size 0 is ignored.
- State IDLE:
  - If flush pending, handle the flush (see below).
  - Otherwise, if i_enable, i_ppfifo_rdy, and the active slot is armed and unfinished: assert o_ppfifo_act, latch i_ppfifo_size into a word counter, and go to READ.
- State READ:
  - If the block word counter is 0: drop act and go to IDLE.
  - Else if the active slot is unarmed or finished: wait, holding act.
  - Else pulse o_ppfifo_stb for one cycle, capture i_ppfifo_data into o_mem_dat, set o_mem_adr = base + count (32-bit wrap), decrement the block counter, and go to WRITE.
- State WRITE:
  - Assert cyc, stb and we until i_mem_ack is seen.
  - On ack: deassert cyc and stb on the next edge and increment count.
  - If count then equals size: set the slot's finished flag, set empty=1, pulse o_write_finished, and toggle the active slot.
  - Return to READ.
  - Latency is at least 2 clocks per word; there is no wait on a zero-wait-state slave.
- A block larger than the remaining slot space continues into the other slot once that slot is armed; act stays held meanwhile.
- Flush:
  - i_flush sets flush pending in any state.
  - It is serviced only in IDLE, so an in-progress block always completes.
  - If the active slot is armed and its count > 0, the slot finishes as above (count stays at the partial value).
  - If count is 0, the flush is discarded.
  - Flush pending is cleared in both cases.
- A finished slot keeps finished=1 and its count until it is re-armed.
- i_enable low only blocks new blocks; a block already in progress still drains.
- i_mem_dat and i_mem_int are ignored.
- An asynchronous reset mid-transfer drops cyc, stb and act immediately.

Test Plan:
1. Arm slot 0 (base 0x100, size 4), feed one 4-word block (1,2,3,4) with a 1-cycle ack → writes to 0x100..0x103 with the same data; count0=4; finished0=1; empty0=1; one o_write_finished pulse; active slot becomes 1.
2. Arm both slots with size 3, feed one 5-word block → slot 0 receives words 1–3 and finishes; slot 1 receives words 4–5 at base1, base1+1; count1=2; finished1=0; act drops after word 5.
3. Slot 0 armed with size 8, a 3-word block, then i_flush → finished0=1 with count0=3; a second flush with count 0 in slot 1 has no effect.
4. Ack delayed by 5 cycles → cyc and stb held for the full 6 cycles; only one o_ppfifo_stb per word.
5. i_enable=0 with rdy high → act never asserts; once enable rises, the transfer starts from IDLE within 2 cycles.
6. Assert rst low mid-WRITE → bus and FIFO outputs go to 0 asynchronously; counts are 0 and empty flags are 1 after release.
